// File: rtl/line_merge_pkg.sv
// rtl/line_merge_pkg.sv - shared state enum, default parameters and clog2 helper for the line write merger
package line_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_LINE_BITS  = 512;
    localparam int DEF_WORD_BITS  = 32;
    localparam int DEF_AUTO_FLUSH = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/word_byte_merge.sv
// rtl/word_byte_merge.sv - combinational byte-enable merge of a new word onto an old word
module word_byte_merge #(
    parameter int WORD_BITS = 32,
    localparam int BE_BITS  = WORD_BITS / 8
) (
    input  logic [WORD_BITS-1:0] i_old_word,
    input  logic [WORD_BITS-1:0] i_new_word,
    input  logic [BE_BITS-1:0]   i_be,
    output logic [WORD_BITS-1:0] o_word
);

    always_comb begin
        o_word = i_old_word;
        for (int b = 0; b < BE_BITS; b++) begin
            if (i_be[b]) o_word[8*b +: 8] = i_new_word[8*b +: 8];
        end
    end

endmodule

// File: rtl/line_write_merger.sv
// rtl/line_write_merger.sv - holds one cache line, merges byte-enabled word writes, drains it on flush
module line_write_merger
    import line_merge_pkg::*;
#(
    parameter int LINE_BITS  = DEF_LINE_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS,
    parameter int AUTO_FLUSH = DEF_AUTO_FLUSH,
    localparam int WORDS     = LINE_BITS / WORD_BITS,
    localparam int OFF_BITS  = clog2(WORDS),
    localparam int BE_BITS   = WORD_BITS / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [LINE_BITS-1:0] ld_line,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [OFF_BITS-1:0]  wr_offset,
    input  logic [WORD_BITS-1:0] wr_data,
    input  logic [BE_BITS-1:0]   wr_be,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LINE_BITS-1:0] out_line,
    output logic [WORDS-1:0]     out_dirty
);

    if ((WORDS < 2) || ((WORDS & (WORDS - 1)) != 0) || ((WORD_BITS % 8) != 0) ||
        (WORDS * WORD_BITS != LINE_BITS)) begin : g_bad_params
        $error("line_write_merger: WORDS must be a power of two >= 2 and WORD_BITS a multiple of 8");
    end

    state_e                          r_state;
    logic [WORDS-1:0][WORD_BITS-1:0] r_line;
    logic [WORDS-1:0]                r_dirty;
    logic                            r_ld_ready;
    logic                            r_wr_ready;
    logic                            r_out_valid;

    logic [WORD_BITS-1:0] w_merged;
    logic                 w_wr_fire;
    logic                 w_be_any;
    logic [WORDS-1:0]     w_dirty_next;
    logic                 w_auto;

    word_byte_merge #(.WORD_BITS(WORD_BITS)) u_merge (
        .i_old_word (r_line[wr_offset]),
        .i_new_word (wr_data),
        .i_be       (wr_be),
        .o_word     (w_merged)
    );

    assign w_wr_fire    = wr_valid & r_wr_ready;
    assign w_be_any     = |wr_be;
    assign w_dirty_next = r_dirty | ({{(WORDS-1){1'b0}}, 1'b1} << wr_offset);
    // Auto drain fires on the write that completes the mask, exactly as a flush would
    assign w_auto       = (AUTO_FLUSH != 0) && w_wr_fire && w_be_any && (&w_dirty_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_line      <= '0;
            r_dirty     <= '0;
            r_ld_ready  <= 1'b1;
            r_wr_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ld_valid) begin
                        r_line     <= ld_line;
                        r_dirty    <= '0;
                        r_ld_ready <= 1'b0;
                        r_wr_ready <= 1'b1;
                        r_state    <= ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    if (w_wr_fire && w_be_any) begin
                        r_line[wr_offset] <= w_merged;
                        r_dirty           <= w_dirty_next;
                    end
                    if (flush || w_auto) begin
                        r_wr_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        r_dirty     <= '0;
                        r_out_valid <= 1'b0;
                        r_ld_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_ld_ready  <= 1'b1;
                    r_wr_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld_ready  = r_ld_ready;
    assign wr_ready  = r_wr_ready;
    assign out_valid = r_out_valid;
    assign out_line  = r_line;
    assign out_dirty = r_dirty;

endmodule

// File: tb/tb_line_write_merger.sv
// tb/tb_line_write_merger.sv - randomized self-checking bench against a word/byte reference model
module tb_line_write_merger;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sel;
    logic         ld_valid, wr_valid, flush, out_ready;
    logic [511:0] ld_line;
    logic [3:0]   wr_offset;
    logic [31:0]  wr_data;
    logic [3:0]   wr_be;

    logic         ld_ready0, wr_ready0, out_valid0;
    logic [511:0] out_line0;
    logic [15:0]  out_dirty0;
    logic         ld_ready1, wr_ready1, out_valid1;
    logic [511:0] out_line1;
    logic [15:0]  out_dirty1;

    logic [511:0] m_line;
    logic [15:0]  m_dirty;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    line_write_merger #(.AUTO_FLUSH(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid & ~sel), .ld_ready(ld_ready0), .ld_line(ld_line),
        .wr_valid(wr_valid & ~sel), .wr_ready(wr_ready0), .wr_offset(wr_offset),
        .wr_data(wr_data), .wr_be(wr_be), .flush(flush & ~sel),
        .out_valid(out_valid0), .out_ready(out_ready & ~sel),
        .out_line(out_line0), .out_dirty(out_dirty0)
    );

    line_write_merger #(.AUTO_FLUSH(1)) dut_af (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid & sel), .ld_ready(ld_ready1), .ld_line(ld_line),
        .wr_valid(wr_valid & sel), .wr_ready(wr_ready1), .wr_offset(wr_offset),
        .wr_data(wr_data), .wr_be(wr_be), .flush(flush & sel),
        .out_valid(out_valid1), .out_ready(out_ready & sel),
        .out_line(out_line1), .out_dirty(out_dirty1)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] fill_line(input logic [31:0] w);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = w;
        return l;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Reference: each enabled byte lane of the addressed word takes the new byte
    task automatic model_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) m_line[off*32 + b*8 +: 8] = d[b*8 +: 8];
        if (be != 4'd0) m_dirty[off] = 1'b1;
    endtask

    task automatic do_load(input logic [511:0] l);
        ld_line  = l;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        m_line   = l;
        m_dirty  = '0;
    endtask

    task automatic do_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] be,
                            input logic fl);
        wr_offset = off;
        wr_data   = d;
        wr_be     = be;
        wr_valid  = 1'b1;
        flush     = fl;
        tick();
        wr_valid  = 1'b0;
        flush     = 1'b0;
        model_write(off, d, be);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic handshake0(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ld_ready"}, ld_ready0, 1'b1);
        chk({tag, "_out_valid_low"}, out_valid0, 1'b0);
        chk({tag, "_dirty_clr"}, out_dirty0, 16'h0);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        ld_valid = 0; wr_valid = 0; flush = 0; out_ready = 0;
        ld_line = '0; wr_offset = '0; wr_data = '0; wr_be = '0;

        tick(); tick();
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_wr_ready", wr_ready0, 1'b0);
        chk("rst_dirty", out_dirty0, 16'h0);
        chk("rst_line", out_line0, '0);
        rst_n = 1'b1;
        tick();
        chk("rst_ld_ready", ld_ready0, 1'b1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_ignored", out_valid0, 1'b0);
        chk("idle_flush_ld_ready", ld_ready0, 1'b1);

        // Full-word write onto a patterned line
        do_load(fill_line(32'hAAAAAAAA));
        chk("load_wr_ready", wr_ready0, 1'b1);
        chk("load_ld_ready", ld_ready0, 1'b0);
        do_write(4'd3, 32'h11223344, 4'b1111, 1'b0);
        chk("w3_line", out_line0, m_line);
        do_flush();
        chk("w3_out_valid", out_valid0, 1'b1);
        chk("w3_out_line", out_line0, m_line);
        chk("w3_dirty", out_dirty0, 16'h0008);
        handshake0("w3");

        // Partial byte enables, then an all-disabled write
        do_load('0);
        do_write(4'd0, 32'hFFFFFFFF, 4'b0101, 1'b0);
        chk("be_word0", out_line0[31:0], 32'h00FF00FF);
        chk("be_dirty0", out_dirty0, 16'h0001);
        do_write(4'd5, 32'h12345678, 4'b0000, 1'b0);
        chk("be0_dirty", out_dirty0, 16'h0001);
        chk("be0_line", out_line0, m_line);
        do_flush();
        handshake0("be");

        // Write merged in the same cycle as flush, then a stalled consumer
        do_load(rand_line());
        do_write(4'd7, $urandom, 4'b1111, 1'b1);
        chk("wf_out_valid", out_valid0, 1'b1);
        chk("wf_line", out_line0, m_line);
        chk("wf_dirty", out_dirty0, 16'h0080);
        wr_valid = 1'b1; wr_offset = 4'd2; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_line", out_line0, m_line);
            chk("stall_dirty", out_dirty0, 16'h0080);
            chk("stall_ld_ready", ld_ready0, 1'b0);
            chk("stall_wr_ready", wr_ready0, 1'b0);
            chk("stall_out_valid", out_valid0, 1'b1);
        end
        wr_valid = 1'b0;
        handshake0("wf");

        // Random merge rounds against the model
        for (int r = 0; r < 8; r++) begin
            int n;
            do_load(rand_line());
            n = $urandom_range(30, 4);
            for (int c = 0; c < n; c++) begin
                logic v;
                logic last;
                last      = (c == n - 1);
                v         = ($urandom_range(3, 0) != 0);
                wr_offset = 4'($urandom);
                wr_data   = $urandom;
                wr_be     = 4'($urandom);
                wr_valid  = v;
                flush     = last;
                tick();
                wr_valid  = 1'b0;
                flush     = 1'b0;
                if (v) model_write(wr_offset, wr_data, wr_be);
                chk("rnd_line", out_line0, m_line);
                chk("rnd_dirty", out_dirty0, m_dirty);
                chk("rnd_out_valid", out_valid0, last);
            end
            for (int s = 0; s < int'($urandom_range(3, 0)); s++) begin
                tick();
                chk("rnd_hold_line", out_line0, m_line);
            end
            handshake0("rnd");
        end

        // Auto-flush instance: 16 back-to-back full writes
        sel = 1'b1;
        do_load(rand_line());
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), $urandom, 4'b1111, 1'b0);
            if (i < 15) begin
                chk("af_not_yet", out_valid1, 1'b0);
                chk("af_wr_ready", wr_ready1, 1'b1);
            end
        end
        chk("af_out_valid", out_valid1, 1'b1);
        chk("af_dirty", out_dirty1, 16'hFFFF);
        chk("af_wr_ready_low", wr_ready1, 1'b0);
        chk("af_line", out_line1, m_line);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("af_ld_ready", ld_ready1, 1'b1);
        sel = 1'b0;

        // Reset in the middle of a drain
        do_load(rand_line());
        do_write(4'd9, $urandom, 4'b1111, 1'b1);
        chk("rd_out_valid", out_valid0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("rd_async_valid", out_valid0, 1'b0);
        chk("rd_async_dirty", out_dirty0, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rd_ld_ready", ld_ready0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_no_valid", out_valid0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_write_merger.md
LINE_WRITE_MERGER -- requirements
Module: line_write_merger

Interface
REQ-001 SHALL have parameter LINE_BITS, default 512, cache line width in bits.
REQ-002 SHALL have parameter WORD_BITS, default 32, write word width; WORDS = LINE_BITS/WORD_BITS, OFF_BITS = clog2(WORDS), BE_BITS = WORD_BITS/8.
REQ-003 SHALL have parameter AUTO_FLUSH, default 0, 1 = drain automatically once every word is dirty.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 ld_valid input 1 line-load request; ld_ready output 1 load accepted; ld_line input LINE_BITS line from memory/cache array.
REQ-006 wr_valid input 1 word-write request; wr_ready output 1 write accepted; wr_offset input OFF_BITS word index; wr_data input WORD_BITS write data; wr_be input BE_BITS byte enables.
REQ-007 flush input 1 request to emit the merged line.
REQ-008 out_valid output 1 merged line available; out_ready input 1 consumer accepts; out_line output LINE_BITS merged line; out_dirty output WORDS per-word written mask.

Function
REQ-009 SHALL implement FSM states IDLE, MERGE, DRAIN.
REQ-010 IDLE: ld_ready=1, wr_ready=0, out_valid=0; ld_valid=1 at an edge SHALL capture ld_line into the line register, clear the dirty mask, move to MERGE.
REQ-011 MERGE: wr_ready=1, ld_ready=0; each accepted write SHALL replace only bytes b of word wr_offset where wr_be[b]=1 (byte b = bits [8b+7:8b] of the word); other bytes/words unchanged.
REQ-012 Accepted write with any wr_be bit set SHALL set out_dirty[wr_offset]; wr_be=0 SHALL be accepted with no state change.
REQ-013 Writes SHALL be accepted every cycle (throughput 1/cycle); a write is visible in the line register one cycle after acceptance.
REQ-014 flush=1 in MERGE SHALL move to DRAIN at the same edge; a write accepted in that same cycle SHALL be merged before draining.
REQ-015 AUTO_FLUSH=1: a write that makes out_dirty all-ones SHALL move to DRAIN at that edge, identical to flush.
REQ-016 DRAIN: out_valid=1 (registered, asserted the cycle after the transition edge), wr_ready=0, ld_ready=0; out_line/out_dirty SHALL be stable while out_valid=1 and out_ready=0.
REQ-017 out_valid & out_ready at an edge SHALL clear the dirty mask and return to IDLE; ld_ready=1 the following cycle.
REQ-018 flush in IDLE or DRAIN SHALL be ignored; wr_valid outside MERGE SHALL be ignored (not accepted, not lost — producer holds).
REQ-019 out_line SHALL reflect the line register in all states; out_dirty the current mask.
REQ-020 Elaboration SHALL fail unless WORDS is a power of two >= 2 and WORD_BITS is a multiple of 8.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state IDLE, line register 0, dirty mask 0, out_valid=0, wr_ready=0; ld_ready=1 after release.
REQ-022 Reset during MERGE or DRAIN SHALL discard the pending line; no out_valid after release until a new load and flush.

Structure
REQ-023 Package line_merge_pkg SHALL hold the state enum, default parameter constants, and the clog2 helper.
REQ-024 Per-word byte merge SHALL be a combinational sub-module word_byte_merge (old word, new word, be -> merged word), instantiated once on the selected word.

Verification
REQ-025 Load line all 0xAAAAAAAA, write offset 3 data 0x11223344 be 4'b1111, flush -> out_line word3=0x11223344, others 0xAAAAAAAA, out_dirty=16'h0008.
REQ-026 Load all-zero, write offset 0 data 0xFFFFFFFF be 4'b0101 -> word0=0x00FF00FF, out_dirty[0]=1; be=0 write to offset 5 leaves out_dirty[5]=0.
REQ-027 AUTO_FLUSH=1, 16 back-to-back writes offsets 0..15 -> DRAIN entered on 16th write edge, out_valid next cycle, out_dirty=16'hFFFF, wr_ready=0.
REQ-028 Write offset 7 and flush in same cycle -> drained line contains the write; hold out_ready=0 for 5 cycles -> out_line stable, ld_ready=0, then handshake -> IDLE.
REQ-029 rst_n pulsed low mid-DRAIN -> out_valid=0 immediately, ld_ready=1 after release, out_dirty=0.
